axil_regbank_slave: RTL and testbench
=====================================

Name: axil_regbank_slave

Overview:
Parametrised AXI4-Lite slave endpoint exposing a bank of NUM_REGS read/write control registers to hardware. Generalises the fixed 4-bit-address/32-bit-data AXI-Lite signal set to configurable address width, data width and register count. Adds independent AW/W buffering, byte strobes, range-checked decode with SLVERR, and per-register write pulses. Sits between the testbench/host AXI-Lite master and the I2C bridge control logic.

Parameters:
ADDR_WIDTH, 4, byte address width; must be ≥ clog2(NUM_REGS) + LANE_BITS
DATA_WIDTH, 32, data width; 32 or 64 only
NUM_REGS, 4, number of registers, 1..64
RESET_VAL, 0, reset value applied to every register, DATA_WIDTH bits
LANE_BITS (localparam), clog2(DATA_WIDTH/8), byte-offset bits ignored in decode

Ports:
clk  in  1  clock
rst  in  1  synchronous reset, active-low
awaddr  in  ADDR_WIDTH  write address
awprot  in  3  write protection
awvalid/awready  in/out  1  AW handshake
wdata  in  DATA_WIDTH  write data
wstrb  in  DATA_WIDTH/8  byte strobes
wvalid/wready  in/out  1  W handshake
bresp  out  2  write response
bvalid/bready  out/in  1  B handshake
araddr  in  ADDR_WIDTH  read address
arprot  in  3  read protection
arvalid/arready  in/out  1  AR handshake
rdata  out  DATA_WIDTH  read data
rresp  out  2  read response
rvalid/rready  out/in  1  R handshake
regs_o  out  NUM_REGS*DATA_WIDTH  flattened register contents, reg i at [i*DATA_WIDTH +: DATA_WIDTH]
wr_pulse_o  out  NUM_REGS  one-cycle pulse on the cycle after reg i is committed

Behaviour:
- Reset (rst=0 at posedge): awready=1, wready=1, arready=1, bvalid=0, rvalid=0, bresp=0, rresp=0, rdata=0, wr_pulse_o=0, all regs=RESET_VAL, AW/W holding buffers empty. Reset mid-transaction discards any pending AW/W/B/R without a response.
- Word index = addr[ADDR_WIDTH-1:LANE_BITS]; low LANE_BITS ignored (unaligned address maps to its containing word).
- AW and W are accepted independently into separate one-entry holding buffers; awready = !aw_held, wready = !w_held. Either order, or both in the same cycle, is legal.
- Commit: on a posedge where aw_held && w_held && (!bvalid || bready): if index < NUM_REGS, byte lane k updated only where wstrb[k]=1, bresp=OKAY(00); otherwise no register changes and bresp=SLVERR(10). Both buffers cleared, bvalid=1 from the next cycle. wr_pulse_o[index]=1 for exactly one cycle after a valid commit (even if wstrb=0).
- Latency: bvalid rises 2 cycles after the later of the AW/W handshakes when B is free. bvalid held with bresp stable until bready; a new commit may occur on the same edge that B completes.
- Back-pressure: with bvalid=1 and bready=0, up to one further AW and one W are buffered, then awready/wready drop.
- Read: arready = !rvalid. AR handshake at edge T → rvalid=1 from T+1 with rdata=reg[index], rresp=OKAY; out-of-range → rdata=0, rresp=SLVERR. rdata/rresp stable until rready; arready returns high the cycle after the R handshake.
- Simultaneous read handshake and write commit to the same register on one edge: read returns the pre-commit value.
- awprot/arprot ignored unless the optional feature is enabled.

Optional Feature:
Macro AXIL_REGBANK_PROT_CHECK_EN. Defined: a write whose buffered awprot[0]=0 (unprivileged) is a SLVERR commit with no register update and no wr_pulse_o; a read with arprot[0]=0 returns rdata=0, rresp=SLVERR. Undefined: awprot/arprot completely ignored, no extra logic.

Test Plan:
- Reset then read all 4 regs (defaults) → each rdata=0x00000000, rresp=00; awready=wready=arready=1 during reset.
- AW(addr 0x4) and W(0xDEADBEEF, wstrb=1111) same cycle → bvalid 2 cycles later, bresp=00, regs_o[63:32]=0xDEADBEEF, wr_pulse_o=0010 for one cycle; read 0x4 returns 0xDEADBEEF.
- W(0x000000AA, wstrb=0001) 3 cycles before AW(addr 0x8), after reg2 preset to 0x11223344 → reg2=0x112233AA, bresp=00.
- Write addr 0xC with NUM_REGS=3 → bresp=10, no register change, no wr_pulse_o; read 0xC → rdata=0, rresp=10.
- Hold bready=0 for 5 cycles after first write, issue second AW/W → second pair buffered, awready=wready=0 until bready=1; second bresp follows within 1 cycle of first B handshake.
- Assert rst=0 with rvalid=1 and a pending AW held → next cycle rvalid=0, bvalid=0, buffers empty, regs=RESET_VAL; with AXIL_REGBANK_PROT_CHECK_EN, write with awprot=000 → bresp=10, register unchanged.

Source files
------------

// File: rtl/axil_regbank_slave.sv
// axil_regbank_slave: parametrised AXI4-Lite slave exposing NUM_REGS r/w
// control registers. AW and W land in independent one-entry holding buffers;
// a write commits once both are held and the B channel is free.
// Optional build macro: AXIL_REGBANK_PROT_CHECK_EN (reject unprivileged access).
module axil_regbank_slave #(
  parameter int ADDR_WIDTH = 4,
  parameter int DATA_WIDTH = 32,
  parameter int NUM_REGS   = 4,
  parameter logic [DATA_WIDTH-1:0] RESET_VAL = '0
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [ADDR_WIDTH-1:0]          awaddr,
  input  logic [2:0]                     awprot,
  input  logic                           awvalid,
  output logic                           awready,
  input  logic [DATA_WIDTH-1:0]          wdata,
  input  logic [DATA_WIDTH/8-1:0]        wstrb,
  input  logic                           wvalid,
  output logic                           wready,
  output logic [1:0]                     bresp,
  output logic                           bvalid,
  input  logic                           bready,
  input  logic [ADDR_WIDTH-1:0]          araddr,
  input  logic [2:0]                     arprot,
  input  logic                           arvalid,
  output logic                           arready,
  output logic [DATA_WIDTH-1:0]          rdata,
  output logic [1:0]                     rresp,
  output logic                           rvalid,
  input  logic                           rready,
  output logic [NUM_REGS*DATA_WIDTH-1:0] regs_o,
  output logic [NUM_REGS-1:0]            wr_pulse_o
);

  localparam int STRB_W    = DATA_WIDTH / 8;
  localparam int LANE_BITS = $clog2(STRB_W);
  localparam int IDX_W     = ADDR_WIDTH - LANE_BITS;
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  // Holding buffers; only the word index of the address is kept.
  logic                  aw_held_q, aw_held_d;
  logic [IDX_W-1:0]      aw_idx_q,  aw_idx_d;
  logic                  w_held_q,  w_held_d;
  logic [DATA_WIDTH-1:0] w_data_q,  w_data_d;
  logic [STRB_W-1:0]     w_strb_q,  w_strb_d;
  logic                  bvalid_q,  bvalid_d;
  logic [1:0]            bresp_q,   bresp_d;
  logic                  rvalid_q,  rvalid_d;
  logic [DATA_WIDTH-1:0] rdata_q,   rdata_d;
  logic [1:0]            rresp_q,   rresp_d;
  logic [NUM_REGS-1:0]   wr_pulse_q, wr_pulse_d;
  logic [NUM_REGS-1:0][DATA_WIDTH-1:0] regs_q, regs_d;

  logic aw_hs, w_hs, ar_hs, commit;
  logic wr_hit, wr_ok, rd_hit, rd_ok;
  logic [NUM_REGS-1:0]   wr_sel;
  logic [DATA_WIDTH-1:0] rd_word;
  logic [IDX_W-1:0]      ar_idx;

`ifdef AXIL_REGBANK_PROT_CHECK_EN
  logic aw_priv_q, aw_priv_d;
  logic unused_bits;
  assign unused_bits = ^{awaddr[LANE_BITS-1:0], araddr[LANE_BITS-1:0],
                         awprot[2:1], arprot[2:1]};
`else
  logic unused_bits;
  assign unused_bits = ^{awaddr[LANE_BITS-1:0], araddr[LANE_BITS-1:0],
                         awprot, arprot};
`endif

  assign awready    = !aw_held_q;
  assign wready     = !w_held_q;
  assign arready    = !rvalid_q;
  assign bvalid     = bvalid_q;
  assign bresp      = bresp_q;
  assign rvalid     = rvalid_q;
  assign rdata      = rdata_q;
  assign rresp      = rresp_q;
  assign regs_o     = regs_q;
  assign wr_pulse_o = wr_pulse_q;

  assign aw_hs  = awvalid && !aw_held_q;
  assign w_hs   = wvalid && !w_held_q;
  assign ar_hs  = arvalid && !rvalid_q;
  assign commit = aw_held_q && w_held_q && (!bvalid_q || bready);
  assign ar_idx = araddr[ADDR_WIDTH-1:LANE_BITS];

  // Decode the buffered write index and the live read index against the bank.
  always_comb begin
    wr_hit  = 1'b0;
    wr_sel  = '0;
    rd_hit  = 1'b0;
    rd_word = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (aw_idx_q == IDX_W'(i)) begin
        wr_hit    = 1'b1;
        wr_sel[i] = 1'b1;
      end
      if (ar_idx == IDX_W'(i)) begin
        rd_hit  = 1'b1;
        rd_word = regs_q[i];
      end
    end
`ifdef AXIL_REGBANK_PROT_CHECK_EN
    wr_ok = wr_hit && aw_priv_q;
    rd_ok = rd_hit && arprot[0];
`else
    wr_ok = wr_hit;
    rd_ok = rd_hit;
`endif
  end

  // Next-state for buffers, channels and the register bank.
  always_comb begin
    aw_held_d  = aw_held_q;
    aw_idx_d   = aw_idx_q;
    w_held_d   = w_held_q;
    w_data_d   = w_data_q;
    w_strb_d   = w_strb_q;
    bvalid_d   = bvalid_q;
    bresp_d    = bresp_q;
    rvalid_d   = rvalid_q;
    rdata_d    = rdata_q;
    rresp_d    = rresp_q;
    regs_d     = regs_q;
    wr_pulse_d = '0;
`ifdef AXIL_REGBANK_PROT_CHECK_EN
    aw_priv_d  = aw_priv_q;
`endif
    // Commit frees both buffers; the B slot is either empty or retiring now.
    if (commit) begin
      aw_held_d = 1'b0;
      w_held_d  = 1'b0;
      bvalid_d  = 1'b1;
      bresp_d   = wr_ok ? RESP_OKAY : RESP_SLVERR;
      if (wr_ok) begin
        wr_pulse_d = wr_sel;
        for (int i = 0; i < NUM_REGS; i++)
          for (int b = 0; b < STRB_W; b++)
            if (wr_sel[i] && w_strb_q[b])
              regs_d[i][b*8 +: 8] = w_data_q[b*8 +: 8];
      end
    end else if (bready) begin
      bvalid_d = 1'b0;
    end
    // A handshake can only happen on an empty buffer, so it never races commit.
    if (aw_hs) begin
      aw_held_d = 1'b1;
      aw_idx_d  = awaddr[ADDR_WIDTH-1:LANE_BITS];
`ifdef AXIL_REGBANK_PROT_CHECK_EN
      aw_priv_d = awprot[0];
`endif
    end
    if (w_hs) begin
      w_held_d = 1'b1;
      w_data_d = wdata;
      w_strb_d = wstrb;
    end
    // Read data is taken from regs_q, so a same-edge commit is not visible.
    if (ar_hs) begin
      rvalid_d = 1'b1;
      rdata_d  = rd_ok ? rd_word : '0;
      rresp_d  = rd_ok ? RESP_OKAY : RESP_SLVERR;
    end else if (rready) begin
      rvalid_d = 1'b0;
    end
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      aw_held_q  <= 1'b0;
      aw_idx_q   <= '0;
      w_held_q   <= 1'b0;
      w_data_q   <= '0;
      w_strb_q   <= '0;
      bvalid_q   <= 1'b0;
      bresp_q    <= RESP_OKAY;
      rvalid_q   <= 1'b0;
      rdata_q    <= '0;
      rresp_q    <= RESP_OKAY;
      wr_pulse_q <= '0;
      for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= RESET_VAL;
`ifdef AXIL_REGBANK_PROT_CHECK_EN
      aw_priv_q  <= 1'b0;
`endif
    end else begin
      aw_held_q  <= aw_held_d;
      aw_idx_q   <= aw_idx_d;
      w_held_q   <= w_held_d;
      w_data_q   <= w_data_d;
      w_strb_q   <= w_strb_d;
      bvalid_q   <= bvalid_d;
      bresp_q    <= bresp_d;
      rvalid_q   <= rvalid_d;
      rdata_q    <= rdata_d;
      rresp_q    <= rresp_d;
      wr_pulse_q <= wr_pulse_d;
      regs_q     <= regs_d;
`ifdef AXIL_REGBANK_PROT_CHECK_EN
      aw_priv_q  <= aw_priv_d;
`endif
    end
  end

endmodule

// File: tb/tb_axil_regbank_slave.sv
// Bench for axil_regbank_slave: NUM_REGS=3 so word 3 (0xC) is out of range.
// Table of write/read vectors plus hand sequences for buffering, back-pressure,
// mid-transaction reset and (if built with it) the protection check.
module tb_axil_regbank_slave;
  localparam int AW = 4, DW = 32, NR = 3;

  logic clk = 1'b0, rst = 1'b0;
  logic [AW-1:0] awaddr = '0, araddr = '0;
  logic [2:0] awprot = 3'b001, arprot = 3'b001;
  logic awvalid = 1'b0, wvalid = 1'b0, arvalid = 1'b0;
  logic bready = 1'b1, rready = 1'b1;
  logic [DW-1:0] wdata = '0;
  logic [DW/8-1:0] wstrb = '0;
  logic awready, wready, bvalid, arready, rvalid;
  logic [1:0] bresp, rresp;
  logic [DW-1:0] rdata;
  logic [NR*DW-1:0] regs_o;
  logic [NR-1:0] wr_pulse_o;

  axil_regbank_slave #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_REGS(NR)) dut (
    .clk(clk), .rst(rst),
    .awaddr(awaddr), .awprot(awprot), .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
    .bresp(bresp), .bvalid(bvalid), .bready(bready),
    .araddr(araddr), .arprot(arprot), .arvalid(arvalid), .arready(arready),
    .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready),
    .regs_o(regs_o), .wr_pulse_o(wr_pulse_o));

  always #5 clk = ~clk;

  int total = 0, bad = 0;

  typedef struct { logic [DW-1:0] d; logic [1:0] r; } rexp_t;
  logic [1:0] exp_b_q[$];
  rexp_t      exp_r_q[$];

  typedef struct {
    bit wr; logic [AW-1:0] addr; logic [DW-1:0] data; logic [3:0] strb;
    logic [1:0] resp; logic [NR-1:0] pulse;
  } vec_t;
  vec_t vt[15];

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  // Present AW and/or W from a negedge and hold until the handshake edge.
  task automatic send(input bit do_aw, input bit do_w, input logic [AW-1:0] a,
                      input logic [DW-1:0] d, input logic [3:0] s, input logic [2:0] p);
    int n = 0;
    bit acc;
    @(negedge clk);
    awvalid = do_aw; awaddr = a; awprot = p;
    wvalid = do_w; wdata = d; wstrb = s;
    do begin
      acc = (!do_aw || awready) && (!do_w || wready);
      if (!acc) @(negedge clk);
      n++;
    end while (!acc && n < 20);
    if (!acc) check("send_timeout", 0, 1);
    @(posedge clk); #1;
    awvalid = 1'b0; wvalid = 1'b0;
  endtask

  // Called right after a handshake edge; expects bvalid after lat negedges.
  task automatic collect_b(input logic [NR-1:0] pulse, input int lat);
    int cyc = 0;
    logic [1:0] e;
    do begin @(negedge clk); cyc++; end while (!bvalid && cyc < 20);
    check("b_latency", cyc, lat);
    if (exp_b_q.size() == 0) check("b_queue_empty", 1, 0);
    else begin e = exp_b_q.pop_front(); check("bresp", bresp, e); end
    check("wr_pulse", wr_pulse_o, pulse);
    @(negedge clk);
    check("pulse_width", wr_pulse_o, 0);
    check("b_retired", bvalid, 0);
  endtask

  task automatic do_read(input logic [AW-1:0] a, input logic [2:0] p);
    int cyc = 0;
    rexp_t e;
    @(negedge clk);
    arvalid = 1'b1; araddr = a; arprot = p;
    check("arready", arready, 1);
    @(posedge clk); #1;
    arvalid = 1'b0;
    do begin @(negedge clk); cyc++; end while (!rvalid && cyc < 20);
    check("r_latency", cyc, 1);
    if (exp_r_q.size() == 0) check("r_queue_empty", 1, 0);
    else begin
      e = exp_r_q.pop_front();
      check("rdata", rdata, e.d);
      check("rresp", rresp, e.r);
    end
    @(negedge clk);
    check("r_retired", {rvalid, arready}, 2'b01);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  initial begin
    // {wr, addr, data(or expected rdata), strb, resp, pulse}
    vt[0]  = '{1'b0, 4'h0, 32'h0,        4'h0, 2'b00, 3'b000};
    vt[1]  = '{1'b0, 4'h4, 32'h0,        4'h0, 2'b00, 3'b000};
    vt[2]  = '{1'b0, 4'h8, 32'h0,        4'h0, 2'b00, 3'b000};
    vt[3]  = '{1'b0, 4'hC, 32'h0,        4'h0, 2'b10, 3'b000};
    vt[4]  = '{1'b1, 4'h4, 32'hDEADBEEF, 4'hF, 2'b00, 3'b010};
    vt[5]  = '{1'b0, 4'h4, 32'hDEADBEEF, 4'h0, 2'b00, 3'b000};
    vt[6]  = '{1'b1, 4'h8, 32'h11223344, 4'hF, 2'b00, 3'b100};
    vt[7]  = '{1'b1, 4'hC, 32'h00000055, 4'hF, 2'b10, 3'b000};
    vt[8]  = '{1'b0, 4'hC, 32'h0,        4'h0, 2'b10, 3'b000};
    vt[9]  = '{1'b1, 4'h9, 32'h0000CC00, 4'h2, 2'b00, 3'b100};
    vt[10] = '{1'b0, 4'h8, 32'h1122CC44, 4'h0, 2'b00, 3'b000};
    vt[11] = '{1'b1, 4'h0, 32'hFFFFFFFF, 4'h0, 2'b00, 3'b001};
    vt[12] = '{1'b0, 4'h0, 32'h0,        4'h0, 2'b00, 3'b000};
    vt[13] = '{1'b1, 4'h2, 32'hA5A5A5A5, 4'hC, 2'b00, 3'b001};
    vt[14] = '{1'b0, 4'h3, 32'hA5A50000, 4'h0, 2'b00, 3'b000};

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_ready", {awready, wready, arready}, 3'b111);
    check("rst_valid", {bvalid, rvalid}, 2'b00);
    check("rst_resp_data", {bresp, rresp, rdata}, 0);
    check("rst_regs", regs_o, 0);
    check("rst_pulse", wr_pulse_o, 0);
    rst = 1'b1;

    // Table vectors
    for (int i = 0; i < 15; i++) begin
      if (vt[i].wr) begin
        exp_b_q.push_back(vt[i].resp);
        send(1, 1, vt[i].addr, vt[i].data, vt[i].strb, 3'b001);
        collect_b(vt[i].pulse, 2);
      end else begin
        exp_r_q.push_back('{vt[i].data, vt[i].resp});
        do_read(vt[i].addr, 3'b001);
      end
    end
    check("regs_after_table", regs_o, {32'h1122CC44, 32'hDEADBEEF, 32'hA5A50000});

    // W three cycles ahead of AW, partial strobe
    exp_b_q.push_back(2'b00);
    send(1, 1, 4'h8, 32'h11223344, 4'hF, 3'b001);
    collect_b(3'b100, 2);
    send(0, 1, 4'h0, 32'h000000AA, 4'h1, 3'b001);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("w_only_hold", {wready, awready, bvalid}, 3'b010);
    end
    exp_b_q.push_back(2'b00);
    send(1, 0, 4'h8, 32'h0, 4'h0, 3'b001);
    collect_b(3'b100, 2);
    check("reg2_partial", regs_o[95:64], 32'h112233AA);

    // B back-pressure: second pair buffered behind an unaccepted response
    bready = 1'b0;
    exp_b_q.push_back(2'b00);
    send(1, 1, 4'h4, 32'h01010101, 4'hF, 3'b001);
    exp_b_q.push_back(2'b00);
    send(1, 1, 4'h0, 32'h02020202, 4'hF, 3'b001);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("bp_stall", {awready, wready, bvalid}, 3'b001);
    end
    check("bp_first_bresp", bresp, exp_b_q.pop_front());
    bready = 1'b1;
    @(negedge clk);
    check("bp_second_bvalid", bvalid, 1);
    check("bp_second_bresp", bresp, exp_b_q.pop_front());
    check("bp_second_pulse", wr_pulse_o, 3'b001);
    check("bp_ready_back", {awready, wready}, 2'b11);
    @(negedge clk);
    check("bp_b_retired", bvalid, 0);
    check("bp_regs", regs_o[63:0], {32'h01010101, 32'h02020202});

    // Reset with R pending and AW held
    rready = 1'b0;
    @(negedge clk);
    arvalid = 1'b1; araddr = 4'h4;
    @(posedge clk); #1 arvalid = 1'b0;
    send(1, 0, 4'h0, 32'h0, 4'h0, 3'b001);
    @(negedge clk);
    check("pre_rst_state", {rvalid, awready}, 2'b10);
    rst = 1'b0;
    @(negedge clk);
    check("mid_rst_ctrl", {awready, wready, arready, bvalid, rvalid}, 5'b11100);
    check("mid_rst_regs", regs_o, 0);
    check("mid_rst_rdata", rdata, 0);
    rst = 1'b1; rready = 1'b1;
    send(0, 1, 4'h0, 32'h000000FF, 4'hF, 3'b001);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("aw_buffer_cleared", bvalid, 0);
    end
    exp_b_q.push_back(2'b00);
    send(1, 0, 4'h0, 32'h0, 4'h0, 3'b001);
    collect_b(3'b001, 2);
    check("post_rst_reg0", regs_o[31:0], 32'h000000FF);

`ifdef AXIL_REGBANK_PROT_CHECK_EN
    exp_b_q.push_back(2'b10);
    send(1, 1, 4'h0, 32'h12345678, 4'hF, 3'b000);
    collect_b(3'b000, 2);
    check("prot_reg_unchanged", regs_o[31:0], 32'h000000FF);
    exp_r_q.push_back('{32'h0, 2'b10});
    do_read(4'h0, 3'b000);
    exp_r_q.push_back('{32'h000000FF, 2'b00});
    do_read(4'h0, 3'b001);
`endif

    check("b_queue_drained", exp_b_q.size(), 0);
    check("r_queue_drained", exp_r_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
